// File: rtl/rd_burst_master.sv
// rd_burst_master
// AXI4 read master feeding the conv input buffer. Every request issues one
// INCR burst of BURST_LENGTH beats, and the beats are passed straight through
// to a valid/ready sink with no added latency. While a burst is in flight, one
// further request can wait in the pending slot.
module rd_burst_master #(
    parameter int DATA_WIDTH   = 512,
    parameter int ADDR_WIDTH   = 64,
    parameter int BURST_LENGTH = 4,
    parameter int ARSIZE       = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  clear,
    output logic                  done,
    output logic                  busy,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic [7:0]            m_arlen,
    output logic [2:0]            m_arsize,
    output logic [1:0]            m_arburst,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    output logic [DATA_WIDTH-1:0] o_tdata,
    output logic                  o_valid,
    input  logic                  o_ready
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_DONE
    } state_t;

    localparam logic [7:0] LAST_BEAT = 8'(BURST_LENGTH - 1);

    state_t                r_state;
    logic [7:0]            r_cnt;
    logic                  r_pend;
    logic [ADDR_WIDTH-1:0] r_pend_addr;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic                  r_arvalid;
    logic                  r_done;
    logic                  r_err;

    logic w_idle;
    logic w_in_data;
    logic w_beat;
    logic w_last;
    logic w_pend_live;
    logic w_queue_req;
    logic w_overrun;
    logic w_beat_err;

    assign w_idle    = (r_state == S_IDLE);
    assign w_in_data = (r_state == S_DATA);
    assign w_beat    = w_in_data & m_rvalid & o_ready;
    assign w_last    = (r_cnt == LAST_BEAT);

    // A pending request is served this cycle only if clear is not flushing it.
    assign w_pend_live = r_pend & ~clear;

    // A request is queued when the FSM is busy. It is also queued in IDLE when
    // the pending slot is being issued ahead of it. clear drops such a request.
    assign w_queue_req = req & ~clear & (~w_idle | r_pend);

    // Overrun: a queued request lands on a slot that still holds one.
    assign w_overrun = w_queue_req & r_pend & ~w_idle;

    // Bad response or a misplaced/missing RLAST on a transferred beat.
    assign w_beat_err = w_beat & ((m_rresp != 2'b00) | (m_rlast != w_last));

    // Burst sequencing: IDLE -> ADDR -> DATA -> DONE, with registered AR and done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 8'd0;
            r_araddr  <= '0;
            r_arvalid <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (w_pend_live) begin
                        r_araddr  <= r_pend_addr;
                        r_arvalid <= 1'b1;
                        r_state   <= S_ADDR;
                    end else if (req) begin
                        r_araddr  <= addr;
                        r_arvalid <= 1'b1;
                        r_state   <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (m_arready) begin
                        r_arvalid <= 1'b0;
                        r_cnt     <= 8'd0;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_beat) begin
                        r_cnt <= r_cnt + 8'd1;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done    <= 1'b0;
                    r_arvalid <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    // Single-entry pending slot. The newest request wins, and clear empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
        end else if (clear) begin
            r_pend <= 1'b0;
        end else if (w_queue_req) begin
            r_pend      <= 1'b1;
            r_pend_addr <= addr;
        end else if (w_idle) begin
            r_pend <= 1'b0;
        end
    end

    // Sticky error flag. A new error in the clear cycle is still recorded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_overrun | w_beat_err) begin
            r_err <= 1'b1;
        end else if (clear) begin
            r_err <= 1'b0;
        end
    end

    assign m_araddr  = r_araddr;
    assign m_arvalid = r_arvalid;
    assign m_arlen   = LAST_BEAT;
    assign m_arsize  = 3'(ARSIZE);
    assign m_arburst = 2'b01;

    assign m_rready = w_in_data & o_ready;
    assign o_valid  = w_in_data & m_rvalid;
    assign o_tdata  = m_rdata;

    assign done = r_done;
    assign busy = ~w_idle | r_pend;
    assign err  = r_err;

endmodule

// File: tb/tb_rd_burst_master.sv
// Testbench for rd_burst_master. A randomising AXI read slave and sink drive
// the DUT. The slave records every beat it sends as the expected downstream
// stream, and a monitor collects what actually leaves the DUT.
module tb_rd_burst_master;

    localparam int DW  = 512;
    localparam int AW  = 64;
    localparam int BL  = 4;
    localparam int ASZ = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req;
    logic [AW-1:0] addr;
    logic          clear;
    logic          done;
    logic          busy;
    logic          err;
    logic [AW-1:0] m_araddr;
    logic [7:0]    m_arlen;
    logic [2:0]    m_arsize;
    logic [1:0]    m_arburst;
    logic          m_arvalid;
    logic          m_arready;
    logic [DW-1:0] m_rdata;
    logic [1:0]    m_rresp;
    logic          m_rlast;
    logic          m_rvalid;
    logic          m_rready;
    logic [DW-1:0] o_tdata;
    logic          o_valid;
    logic          o_ready;

    always #5 clk = ~clk;

    rd_burst_master #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .BURST_LENGTH(BL),
        .ARSIZE      (ASZ)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .addr     (addr),
        .clear    (clear),
        .done     (done),
        .busy     (busy),
        .err      (err),
        .m_araddr (m_araddr),
        .m_arlen  (m_arlen),
        .m_arsize (m_arsize),
        .m_arburst(m_arburst),
        .m_arvalid(m_arvalid),
        .m_arready(m_arready),
        .m_rdata  (m_rdata),
        .m_rresp  (m_rresp),
        .m_rlast  (m_rlast),
        .m_rvalid (m_rvalid),
        .m_rready (m_rready),
        .o_tdata  (o_tdata),
        .o_valid  (o_valid),
        .o_ready  (o_ready)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    // Slave and sink behaviour knobs
    int ar_mode    = 0;   // 0: arready always high, 1: random
    int gap_mode   = 0;   // 0: rvalid whenever data is owed, 1: random gaps
    int ordy_mode  = 0;   // 0: high, 1: 1,0,0,1 pattern, 2: random, 3: low
    int inj_resp   = -1;  // beat index that carries RRESP=SLVERR
    int inj_rlast  = -1;  // beat index with an extra early RLAST
    int inj_nolast = 0;   // drop RLAST on the final beat
    int pat        = 0;
    int slv_beat   = 0;

    logic [DW-1:0] slv_q[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got_q[$];
    logic [AW-1:0] got_ar[$];
    int            exp_done[$];
    int            got_done[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    // AXI read slave and downstream sink
    initial begin : drv
        logic ar_hs;
        logic r_hs;
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rdata   = '0;
        m_rresp   = 2'b00;
        m_rlast   = 1'b0;
        o_ready   = 1'b0;
        forever begin
            @(negedge clk);
            ar_hs = rst_n && m_arvalid && m_arready;
            r_hs  = rst_n && m_rvalid && m_rready;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                slv_q.delete();
                slv_beat  = 0;
                pat       = 0;
                m_rvalid  = 1'b0;
                m_rlast   = 1'b0;
                m_rresp   = 2'b00;
                m_arready = 1'b0;
                o_ready   = 1'b0;
            end else begin
                if (ar_hs) begin
                    for (int i = 0; i < BL; i++) begin
                        slv_q.push_back(rand_word());
                        exp_q.push_back(slv_q[$]);
                    end
                end
                if (r_hs) begin
                    void'(slv_q.pop_front());
                    slv_beat = (slv_beat + 1) % BL;
                end
                if (!(m_rvalid && !r_hs)) begin
                    if (slv_q.size() > 0 && (gap_mode == 0 || $urandom_range(0, 3) != 0)) begin
                        m_rvalid = 1'b1;
                        m_rdata  = slv_q[0];
                        m_rresp  = (slv_beat == inj_resp) ? 2'b10 : 2'b00;
                        m_rlast  = ((slv_beat == BL - 1) && (inj_nolast == 0)) || (slv_beat == inj_rlast);
                    end else begin
                        m_rvalid = 1'b0;
                        m_rlast  = 1'b0;
                        m_rresp  = 2'b00;
                    end
                end
                m_arready = (ar_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                case (ordy_mode)
                    0: o_ready = 1'b1;
                    1: begin
                        o_ready = (pat % 4 == 0) || (pat % 4 == 3);
                        pat++;
                    end
                    2: o_ready = 1'($urandom_range(0, 1));
                    default: o_ready = 1'b0;
                endcase
            end
        end
    end

    // Monitor: pass-through rules, AR stability, collected beats, and done timing
    logic          prev_arv = 1'b0;
    logic          prev_arr = 1'b0;
    logic [AW-1:0] prev_ara = '0;
    int            mon_beat = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_beat = 0;
            prev_arv = 1'b0;
        end else begin
            if (slv_q.size() > 0) begin
                chk("rready_mirror", m_rready, o_ready);
                chk("valid_pass", o_valid, m_rvalid);
                if (m_rvalid) chk("tdata_pass", o_tdata, m_rdata);
            end else begin
                chk("rready_idle", m_rready, 1'b0);
                chk("valid_idle", o_valid, 1'b0);
            end
            if (prev_arv && !prev_arr) begin
                chk("arvalid_hold", m_arvalid, 1'b1);
                chk("araddr_hold", m_araddr, prev_ara);
            end
            if (m_arvalid && m_arready) got_ar.push_back(m_araddr);
            if (o_valid && o_ready) begin
                got_q.push_back(o_tdata);
                if (mon_beat == BL - 1) exp_done.push_back(cyc + 1);
                mon_beat = (mon_beat + 1) % BL;
            end
            if (done) got_done.push_back(cyc);
            prev_arv = m_arvalid;
            prev_arr = m_arready;
            prev_ara = m_araddr;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue_req(input logic [AW-1:0] a);
        @(posedge clk);
        #1;
        req  = 1'b1;
        addr = a;
        @(posedge clk);
        #1;
        req  = 1'b0;
    endtask

    task automatic pulse_clear();
        @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    // Returns at the falling edge on which the n-th done pulse is seen.
    task automatic wait_done(input int n, input int budget, input string tag);
        int seen = 0;
        int c = 0;
        while (seen < n && c < budget) begin
            @(negedge clk);
            c++;
            if (done) seen++;
        end
        chk(tag, seen, n);
    endtask

    task automatic wait_beats(input int n, input int budget, input string tag);
        int seen = 0;
        int c = 0;
        while (seen < n && c < budget) begin
            @(negedge clk);
            c++;
            if (o_valid && o_ready) seen++;
        end
        chk(tag, seen, n);
    endtask

    task automatic wait_ar(input int budget, input string tag);
        int found = 0;
        int c = 0;
        while (found == 0 && c < budget) begin
            @(negedge clk);
            c++;
            if (m_arvalid && m_arready) found = 1;
        end
        chk(tag, found, 1);
    endtask

    task automatic check_ar(input string tag, input int idx, input logic [AW-1:0] a);
        chk(tag, (idx < got_ar.size()) ? got_ar[idx] : {AW{1'b1}}, a);
    endtask

    task automatic flush_sb();
        exp_q.delete();
        got_q.delete();
        got_ar.delete();
        exp_done.delete();
        got_done.delete();
    endtask

    // Delivered beats must equal the slave's beats, and each done must follow a final beat by one cycle.
    task automatic check_stream(input string tag, input int nb);
        tick(2);
        chk({tag, "_nbeats"}, got_q.size(), nb * BL);
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk({tag, "_data"}, got_q[i], exp_q[i]);
        chk({tag, "_ndone"}, got_done.size(), nb);
        for (int i = 0; i < got_done.size() && i < exp_done.size(); i++)
            chk({tag, "_done_cyc"}, got_done[i], exp_done[i]);
        flush_sb();
    endtask

    initial begin : main
        logic [AW-1:0] ra;
        rst_n = 1'b0;
        req   = 1'b0;
        addr  = '0;
        clear = 1'b0;
        tick(3);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_arvalid", m_arvalid, 1'b0);
        chk("rst_rready", m_rready, 1'b0);
        chk("rst_ovalid", o_valid, 1'b0);
        chk("rst_araddr", m_araddr, '0);
        rst_n = 1'b1;
        tick(2);

        // Single burst, free-flowing
        issue_req(64'h1000);
        wait_done(1, 50, "t1_done");
        chk("t1_busy_at_done", busy, 1'b1);
        chk("t1_err", err, 1'b0);
        @(negedge clk);
        chk("t1_done_pulse", done, 1'b0);
        chk("t1_busy_after", busy, 1'b0);
        chk("t1_arlen", m_arlen, 8'd3);
        chk("t1_arsize", m_arsize, 3'd6);
        chk("t1_arburst", m_arburst, 2'b01);
        chk("t1_nar", got_ar.size(), 1);
        check_ar("t1_araddr", 0, 64'h1000);
        check_stream("t1", 1);

        // Sink backpressure 1,0,0,1 pattern
        ordy_mode = 1;
        issue_req(64'h2000);
        wait_done(1, 80, "t2_done");
        chk("t2_err", err, 1'b0);
        @(negedge clk);
        chk("t2_busy_after", busy, 1'b0);
        check_ar("t2_araddr", 0, 64'h2000);
        check_stream("t2", 1);

        // Queued request: done, one idle cycle, then AR for the pending address
        ordy_mode = 0;
        issue_req(64'h0);
        wait_beats(1, 50, "t3_first_beat");
        issue_req(64'h100);
        wait_done(1, 50, "t3_done1");
        @(negedge clk);
        chk("t3_gap_arvalid", m_arvalid, 1'b0);
        chk("t3_gap_busy", busy, 1'b1);
        @(negedge clk);
        chk("t3_second_arvalid", m_arvalid, 1'b1);
        chk("t3_second_araddr", m_araddr, 64'h100);
        wait_done(1, 50, "t3_done2");
        chk("t3_err", err, 1'b0);
        check_ar("t3_ar0", 0, 64'h0);
        check_ar("t3_ar1", 1, 64'h100);
        check_stream("t3", 2);

        // Overrun: the last queued address wins and err sticks until clear
        ordy_mode = 3;
        issue_req(64'h0);
        wait_ar(50, "t4_ar0");
        issue_req(64'h100);
        issue_req(64'h200);
        @(negedge clk);
        chk("t4_err_overrun", err, 1'b1);
        chk("t4_busy", busy, 1'b1);
        ordy_mode = 0;
        wait_done(1, 50, "t4_done1");
        wait_done(1, 50, "t4_done2");
        chk("t4_err_sticky", err, 1'b1);
        pulse_clear();
        @(negedge clk);
        chk("t4_err_cleared", err, 1'b0);
        chk("t4_busy_cleared", busy, 1'b0);
        tick(10);
        chk("t4_nar", got_ar.size(), 2);
        check_ar("t4_ar0", 0, 64'h0);
        check_ar("t4_ar1", 1, 64'h200);
        check_stream("t4", 2);

        // clear flushes a pending request but the in-flight burst completes
        ordy_mode = 3;
        issue_req(64'h300);
        wait_ar(50, "t4b_ar0");
        issue_req(64'h400);
        @(negedge clk);
        chk("t4b_busy_pend", busy, 1'b1);
        pulse_clear();
        ordy_mode = 0;
        wait_done(1, 50, "t4b_done");
        @(negedge clk);
        chk("t4b_busy_after", busy, 1'b0);
        tick(10);
        chk("t4b_nar", got_ar.size(), 1);
        check_ar("t4b_ar0", 0, 64'h300);
        chk("t4b_err", err, 1'b0);
        check_stream("t4b", 1);

        // Protocol errors: SLVERR beat forwarded, early RLAST, missing RLAST
        inj_resp = 1;
        issue_req(64'h5000);
        wait_done(1, 50, "t5a_done");
        chk("t5a_err", err, 1'b1);
        check_stream("t5a", 1);
        inj_resp = -1;
        pulse_clear();
        @(negedge clk);
        chk("t5a_err_cleared", err, 1'b0);
        inj_rlast = 2;
        issue_req(64'h5100);
        wait_done(1, 50, "t5b_done");
        chk("t5b_err", err, 1'b1);
        check_stream("t5b", 1);
        inj_rlast = -1;
        pulse_clear();
        inj_nolast = 1;
        issue_req(64'h5200);
        wait_done(1, 50, "t5c_done");
        chk("t5c_err", err, 1'b1);
        check_stream("t5c", 1);
        inj_nolast = 0;

        // Asynchronous reset in the middle of a burst (err still set from above)
        issue_req(64'h6000);
        wait_beats(2, 50, "t6_two_beats");
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_done", done, 1'b0);
        chk("t6_busy", busy, 1'b0);
        chk("t6_err", err, 1'b0);
        chk("t6_arvalid", m_arvalid, 1'b0);
        chk("t6_rready", m_rready, 1'b0);
        chk("t6_ovalid", o_valid, 1'b0);
        chk("t6_araddr", m_araddr, '0);
        tick(3);
        flush_sb();
        rst_n = 1'b1;
        tick(2);
        ar_mode   = 1;
        gap_mode  = 1;
        ordy_mode = 2;
        issue_req(64'h7000);
        wait_done(1, 300, "t6_fresh_done");
        chk("t6_fresh_err", err, 1'b0);
        check_ar("t6_fresh_ar", 0, 64'h7000);
        check_stream("t6_fresh", 1);

        // Randomised bursts
        for (int k = 0; k < 4; k++) begin
            ra        = {$urandom, $urandom} & ~64'h3F;
            ar_mode   = $urandom_range(0, 1);
            gap_mode  = $urandom_range(0, 1);
            ordy_mode = $urandom_range(0, 2);
            issue_req(ra);
            wait_done(1, 300, "t7_done");
            chk("t7_err", err, 1'b0);
            check_ar("t7_araddr", 0, ra);
            check_stream("t7", 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
